// File: rtl/trap_sequencer.sv
// Machine-mode trap/interrupt sequencer: prioritises exceptions and interrupts,
// latches cause/tval/epc, then runs flush -> CSR commit pulse -> PC redirect.
module trap_sequencer #(
  parameter int XLEN     = 32,
  parameter bit VECTORED = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [5:0]      i_ex_vec,
  input  logic            i_mret,
  input  logic            i_boundary,
  input  logic [2:0]      i_irq,
  input  logic            i_mie,
  input  logic [2:0]      i_irq_en,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_tvec,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_flush_ack,
  output logic            o_busy,
  output logic            o_flush_req,
  output logic            o_csr_trap,
  output logic            o_csr_mret,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_tval,
  output logic [XLEN-1:0] o_epc,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]      state_q, state_d;
  logic            mret_q, mret_d;
  logic            intr_q, intr_d;
  logic [3:0]      code_q, code_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic            ex_any;
  logic            irq_take;
  logic [2:0]      irq_pend;
  logic [3:0]      ex_code;
  logic [XLEN-1:0] ex_tval;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] vec_off;

  assign ex_any   = |i_ex_vec;
  assign irq_pend = i_irq & i_irq_en;
  assign irq_take = i_boundary & i_mie & (|irq_pend);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    ex_code  = 4'd0;
    ex_tval  = '0;
    irq_code = 4'd0;
    if (i_ex_vec[5]) begin
      ex_code = 4'd3;
      ex_tval = i_pc;
    end else if (i_ex_vec[4]) begin
      ex_code = 4'd0;
      ex_tval = i_badaddr;
    end else if (i_ex_vec[3]) begin
      ex_code = 4'd2;
      ex_tval = XLEN'(i_inst);
    end else if (i_ex_vec[2]) begin
      ex_code = 4'd11;
    end else if (i_ex_vec[1]) begin
      ex_code = 4'd6;
      ex_tval = i_badaddr;
    end else if (i_ex_vec[0]) begin
      ex_code = 4'd4;
      ex_tval = i_badaddr;
    end
    if (irq_pend[2])      irq_code = 4'd11;
    else if (irq_pend[1]) irq_code = 4'd3;
    else if (irq_pend[0]) irq_code = 4'd7;
  end

  assign vec_off = (VECTORED && intr_q) ? (XLEN'(code_q) << 2) : '0;

  always_comb begin
    state_d = state_q;
    mret_d  = mret_q;
    intr_d  = intr_q;
    code_d  = code_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    epc_d   = epc_q;
    rpc_d   = rpc_q;
    case (state_q)
      S_IDLE: begin
        if (ex_any) begin
          state_d = S_FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b0;
          code_d  = ex_code;
          cause_d = XLEN'(ex_code);
          tval_d  = ex_tval;
          epc_d   = i_pc;
        end else if (irq_take) begin
          state_d = S_FLUSH;
          mret_d  = 1'b0;
          intr_d  = 1'b1;
          code_d  = irq_code;
          cause_d = {1'b1, (XLEN-1)'(irq_code)};
          tval_d  = '0;
          epc_d   = i_pc;
        end else if (i_mret) begin
          // MRET leaves cause/tval/epc untouched; only the CSR stack pop follows.
          state_d = S_FLUSH;
          mret_d  = 1'b1;
          intr_d  = 1'b0;
        end
      end
      S_FLUSH: begin
        if (i_flush_ack) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_REDIRECT;
        rpc_d   = mret_q ? (i_epc & ALIGN_MASK) : ((i_tvec & ALIGN_MASK) + vec_off);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and clears the latched payload too; <= keeps all
  // registers updating from the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mret_q  <= 1'b0;
      intr_q  <= 1'b0;
      code_q  <= 4'd0;
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      mret_q  <= mret_d;
      intr_q  <= intr_d;
      code_q  <= code_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      epc_q   <= epc_d;
      rpc_q   <= rpc_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_flush_req   = (state_q == S_FLUSH);
  assign o_csr_trap    = (state_q == S_COMMIT) && !mret_q;
  assign o_csr_mret    = (state_q == S_COMMIT) && mret_q;
  assign o_redirect    = (state_q == S_REDIRECT);
  assign o_cause       = cause_q;
  assign o_tval        = tval_q;
  assign o_epc         = epc_q;
  assign o_redirect_pc = rpc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised scoreboard bench for trap_sequencer: a driver pushes expected
// commits/redirects from a priority-table model, a negedge monitor pops them.
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam bit VEC  = 1'b1;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [5:0]      i_ex_vec;
  logic            i_mret;
  logic            i_boundary;
  logic [2:0]      i_irq;
  logic            i_mie;
  logic [2:0]      i_irq_en;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_badaddr;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_tvec;
  logic [XLEN-1:0] i_epc;
  logic            i_flush_ack;
  logic            o_busy;
  logic            o_flush_req;
  logic            o_csr_trap;
  logic            o_csr_mret;
  logic [XLEN-1:0] o_cause;
  logic [XLEN-1:0] o_tval;
  logic [XLEN-1:0] o_epc;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;

  trap_sequencer #(.XLEN(XLEN), .VECTORED(VEC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ex_vec(i_ex_vec), .i_mret(i_mret),
    .i_boundary(i_boundary), .i_irq(i_irq), .i_mie(i_mie), .i_irq_en(i_irq_en),
    .i_pc(i_pc), .i_badaddr(i_badaddr), .i_inst(i_inst), .i_tvec(i_tvec),
    .i_epc(i_epc), .i_flush_ack(i_flush_ack), .o_busy(o_busy),
    .o_flush_req(o_flush_req), .o_csr_trap(o_csr_trap), .o_csr_mret(o_csr_mret),
    .o_cause(o_cause), .o_tval(o_tval), .o_epc(o_epc), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          accept;
    bit          mret;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] epc;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen_commit = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the priority tables.
  function automatic exp_t model(input logic [5:0] ex, input logic mret, input logic bnd,
                                 input logic [2:0] irq, input logic mie, input logic [2:0] en,
                                 input logic [31:0] pc, input logic [31:0] bad,
                                 input logic [31:0] inst, input logic [31:0] tv,
                                 input logic [31:0] ep);
    int ex_bit[6]  = '{5, 4, 3, 2, 1, 0};
    int ex_code[6] = '{3, 0, 2, 11, 6, 4};
    int ir_bit[3]  = '{2, 1, 0};
    int ir_code[3] = '{11, 3, 7};
    logic [2:0] pend;
    exp_t e;
    e = '{accept: 0, mret: 0, cause: 0, tval: 0, epc: 0, rpc: 0};
    pend = irq & en;
    if (ex != 0) begin
      for (int i = 0; i < 6; i++) begin
        if (ex[ex_bit[i]] && !e.accept) begin
          e.accept = 1;
          e.cause  = ex_code[i];
          case (ex_code[i])
            3:       e.tval = pc;
            2:       e.tval = inst;
            11:      e.tval = 0;
            default: e.tval = bad;
          endcase
        end
      end
      e.epc = pc;
      e.rpc = tv & 32'hFFFF_FFFC;
    end else if (bnd && mie && pend != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[ir_bit[i]] && !e.accept) begin
          e.accept = 1;
          e.cause  = 32'h8000_0000 | ir_code[i];
          e.rpc    = (tv & 32'hFFFF_FFFC) + (VEC ? ir_code[i] * 4 : 0);
        end
      end
      e.epc = pc;
    end else if (mret) begin
      e.accept = 1;
      e.mret   = 1;
      e.rpc    = ep & 32'hFFFF_FFFC;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    i_ex_vec = 0; i_mret = 0; i_boundary = 0; i_irq = 0; i_mie = 0; i_irq_en = 0;
    i_flush_ack = 0;
  endtask

  // Issue one candidate event; ack_cycle is the cycle (>=1) at which flush_ack is seen.
  task automatic run_event(input logic [5:0] ex, input logic mret, input logic bnd,
                           input logic [2:0] irq, input logic mie, input logic [2:0] en,
                           input logic [31:0] pc, input logic [31:0] bad,
                           input logic [31:0] inst, input logic [31:0] tv,
                           input logic [31:0] ep, input int ack_cycle, input bit toggle);
    exp_t e;
    i_ex_vec = ex; i_mret = mret; i_boundary = bnd; i_irq = irq; i_mie = mie;
    i_irq_en = en; i_pc = pc; i_badaddr = bad; i_inst = inst;
    i_tvec = $urandom; i_epc = $urandom; i_flush_ack = 0;
    e = model(ex, mret, bnd, irq, mie, en, pc, bad, inst, tv, ep);
    if (e.accept) sb_q.push_back(e);
    @(posedge i_clk); #1;
    check("busy_after_accept", 32'(o_busy), 32'(e.accept));
    if (!e.accept) begin
      clear_inputs();
      return;
    end
    check("flush_req_c1", 32'(o_flush_req), 1);
    // tvec/epc only matter in COMMIT; everything else is noise while busy.
    i_tvec = tv; i_epc = ep;
    if (toggle) begin
      i_ex_vec = 6'($urandom); i_mret = 1; i_boundary = 1; i_irq = 3'($urandom);
      i_mie = 1; i_irq_en = 3'b111; i_pc = $urandom; i_badaddr = $urandom;
    end
    for (int c = 1; c < ack_cycle; c++) begin
      @(posedge i_clk); #1;
      check("flush_req_held", 32'(o_flush_req), 1);
      if (toggle) i_irq = ~i_irq;
    end
    clear_inputs();
    i_flush_ack = 1;
    @(posedge i_clk); #1;
    i_flush_ack = 0;
    check("commit_busy", 32'(o_busy), 1);
    check("commit_no_flush", 32'(o_flush_req), 0);
    @(posedge i_clk); #1;
    check("redirect_busy", 32'(o_busy), 1);
    @(posedge i_clk); #1;
    check("idle_after_redirect", 32'(o_busy), 0);
  endtask

  // Monitor: compares every commit/redirect pulse to the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_csr_trap || o_csr_mret) begin
        if (sb_q.size() == 0) begin
          check("unexpected_commit", 1, 0);
        end else begin
          check("commit_is_mret", 32'(o_csr_mret), 32'(sb_q[0].mret));
          check("commit_is_trap", 32'(o_csr_trap), 32'(!sb_q[0].mret));
          if (!sb_q[0].mret) begin
            check("cause", o_cause, sb_q[0].cause);
            check("tval", o_tval, sb_q[0].tval);
            check("epc", o_epc, sb_q[0].epc);
          end
          seen_commit = 1;
        end
      end
      if (o_redirect) begin
        if (sb_q.size() == 0) begin
          check("unexpected_redirect", 1, 0);
        end else begin
          check("commit_before_redirect", 32'(seen_commit), 1);
          check("redirect_pc", o_redirect_pc, sb_q[0].rpc);
          void'(sb_q.pop_front());
          seen_commit = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ex;
    clear_inputs();
    i_pc = 0; i_badaddr = 0; i_inst = 0; i_tvec = 0; i_epc = 0;
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_cause", o_cause, 0);
    check("rst_rpc", o_redirect_pc, 0);
    i_rst = 0;

    // inst_addr beats st_addr
    run_event(6'b010010, 0, 0, 0, 0, 0, 32'h100, 32'h1002, 32'h13, 32'h200, 0, 1, 0);
    // ecall wins over a simultaneous MRET
    run_event(6'b000100, 1, 0, 0, 0, 0, 32'h104, 32'h55, 32'h73, 32'h200, 32'h999, 2, 0);
    // all interrupts pending, vectored
    run_event(0, 0, 1, 3'b111, 1, 3'b111, 32'h180, 0, 0, 32'h201, 0, 1, 0);
    // mti gated by MIE then by boundary
    run_event(0, 0, 1, 3'b001, 0, 3'b001, 32'h10, 0, 0, 32'h400, 0, 1, 0);
    run_event(0, 0, 0, 3'b001, 1, 3'b001, 32'h10, 0, 0, 32'h400, 0, 1, 0);
    run_event(0, 0, 1, 3'b001, 1, 3'b001, 32'h10, 0, 0, 32'h400, 0, 1, 0);
    // MRET, ack at cycle 5 (flush_req held cycles 1..5), irq toggled meanwhile
    run_event(0, 1, 0, 0, 0, 0, 32'h20, 0, 0, 32'h400, 32'h3003, 5, 1);
    // illegal: tval is the instruction word; ebreak: tval is the pc
    run_event(6'b001011, 0, 0, 0, 0, 0, 32'h44, 32'h77, 32'hDEAD_BEEF, 32'h800, 0, 1, 0);
    run_event(6'b111111, 1, 1, 3'b111, 1, 3'b111, 32'h48, 32'h77, 32'h1, 32'h800, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      ex = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      run_event(ex, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(1, 4), 1'($urandom));
    end

    // Reset mid-FLUSH aborts the sequence with no commit and no redirect.
    run_event(6'b000001, 0, 0, 0, 0, 0, 32'h60, 32'hABC, 0, 32'h200, 0, 1, 0);
    i_ex_vec = 6'b000001; i_pc = 32'h64; i_badaddr = 32'h1234;
    @(posedge i_clk); #1;
    clear_inputs();
    @(posedge i_clk); #1;
    check("pre_rst_flush_req", 32'(o_flush_req), 1);
    i_rst = 1;
    @(posedge i_clk); #1;
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_flush", 32'(o_flush_req), 0);
    check("mid_rst_trap", 32'(o_csr_trap), 0);
    check("mid_rst_redirect", 32'(o_redirect), 0);
    check("mid_rst_cause", o_cause, 0);
    check("mid_rst_tval", o_tval, 0);
    check("mid_rst_epc", o_epc, 0);
    check("mid_rst_rpc", o_redirect_pc, 0);
    i_rst = 0;
    i_flush_ack = 1;
    repeat (4) @(posedge i_clk);
    #1;
    i_flush_ack = 0;
    check("post_rst_idle", 32'(o_busy), 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
